// File: rtl/sr_latch_driver.sv
// SR latch pulse driver: accepts a target level, emits one set/reset pulse on s/r/en,
// then confirms q/qn feedback. Optional build macro: SRD_SKIP_REDUNDANT_EN.
module sr_latch_driver #(
  parameter int PULSE_W = 2,
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_val,
  input  logic q_fb,
  input  logic qn_fb,
  output logic s,
  output logic r,
  output logic en,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int PCNT_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0]  CCNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0]  ccnt_q, ccnt_d;
  logic              tgt_q, tgt_d;
  logic              s_q, s_d;
  logic              r_q, r_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              accept_s;
  logic              fb_match_s;
  logic              redundant_s;

  // Complementary, non-equal feedback at the wanted level; X or q==qn never matches.
  function automatic logic fb_matches(input logic q, input logic qn, input logic lvl);
    logic ok;
    ok = 1'b0;
    if ((q != qn) && (q == lvl)) begin
      ok = 1'b1;
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  assign accept_s   = req_valid & ready_q;
  assign fb_match_s = fb_matches(q_fb, qn_fb, tgt_q);

  // Redundant-request detection, only present in the skip build.
  always_comb begin
`ifdef SRD_SKIP_REDUNDANT_EN
    redundant_s = fb_matches(q_fb, qn_fb, req_val);
`else
    redundant_s = 1'b0;
`endif
  end

  // Next-state and next-output computation.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    ccnt_d  = ccnt_q;
    tgt_d   = tgt_q;
    err_d   = err_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          tgt_d  = req_val;
          err_d  = 1'b0;
          pcnt_d = '0;
          if (redundant_s) begin
            done_d = 1'b1;
          end else begin
            state_d = PULSE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      PULSE: begin
        if (pcnt_q == PCNT_LAST) begin
          state_d = CHECK;
          ccnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + PCNT_W'(1);
        end
      end
      CHECK: begin
        if (fb_match_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (ccnt_q == CCNT_LAST) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          ccnt_d = ccnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Drive pins follow the upcoming state so they are flop outputs aligned to it.
    en_d    = (state_d == PULSE);
    s_d     = (state_d == PULSE) &  tgt_d;
    r_d     = (state_d == PULSE) & ~tgt_d;
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      ccnt_q  <= '0;
      tgt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      ccnt_q  <= ccnt_d;
      tgt_q   <= tgt_d;
    end
  end

  // Registered outputs; reset drops latch drive immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      s_q     <= s_d;
      r_q     <= r_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign s         = s_q;
  assign r         = r_q;
  assign en        = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign req_ready = ready_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver with a behavioural SR latch on the feedback pins.
module tb_sr_latch_driver;

  localparam int PULSE_W = 2;
  localparam int TIMEOUT = 8;
  localparam int LAT_OK  = PULSE_W + 2;
  localparam int LAT_TO  = PULSE_W + 1 + TIMEOUT;
`ifdef SRD_SKIP_REDUNDANT_EN
  localparam int  LAT_RED   = 1;
  localparam bit  PULSE_RED = 1'b0;
`else
  localparam int  LAT_RED   = LAT_OK;
  localparam bit  PULSE_RED = 1'b1;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_val = 1'b0;
  logic req_ready, q_fb, qn_fb, s, r, en, busy, done, err;
  logic q_m = 1'b0;
  int   fb_mode = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic val;
    logic err;
    int   lat;
    bit   pulse;
  } exp_t;
  exp_t sb[$];

  sr_latch_driver #(.PULSE_W(PULSE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_val(req_val), .q_fb(q_fb), .qn_fb(qn_fb), .s(s), .r(r), .en(en),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural latch: follows s/r while enabled.
  always @(posedge clk) begin
    if (en && s) q_m <= 1'b1;
    else if (en && r) q_m <= 1'b0;
  end

  always_comb begin
    case (fb_mode)
      0:       begin q_fb = q_m;  qn_fb = ~q_m; end
      1:       begin q_fb = 1'b0; qn_fb = 1'b1; end
      default: begin q_fb = 1'b1; qn_fb = 1'b1; end
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic do_req(input logic val, input logic e_err, input int lat, input bit pulse,
                        input bit hold);
    exp_t e;
    int   k;
    bit   fin;
    logic on;
    @(negedge clk);
    check_eq("ready_before_accept", req_ready, 1'b1);
    req_valid = 1'b1;
    req_val   = val;
    @(posedge clk);
    e.val = val; e.err = e_err; e.lat = lat; e.pulse = pulse;
    sb.push_back(e);
    #1;
    if (!hold) req_valid = 1'b0;
    k = 1;
    fin = 1'b0;
    while (!fin && k <= 40) begin
      on = sb[0].pulse && (k <= PULSE_W);
      check_eq($sformatf("s k=%0d", k), s, on & sb[0].val);
      check_eq($sformatf("r k=%0d", k), r, on & ~sb[0].val);
      check_eq($sformatf("en k=%0d", k), en, on);
      if (done === 1'b1) begin
        e = sb.pop_front();
        check_eq("done_latency", k, e.lat);
        check_eq("err_at_done", err, e.err);
        check_eq("busy_at_done", busy, 1'b0);
        check_eq("ready_at_done", req_ready, 1'b1);
        fin = 1'b1;
      end else begin
        check_eq($sformatf("busy k=%0d", k), busy, 1'b1);
        check_eq($sformatf("ready k=%0d", k), req_ready, 1'b0);
        check_eq($sformatf("err k=%0d", k), err, 1'b0);
        @(posedge clk);
        #1;
        k++;
      end
    end
    if (!fin) begin
      check_eq("done_never_seen", 32'd0, 32'd1);
      void'(sb.pop_front());
    end else if (!hold) begin
      @(posedge clk);
      #1;
      check_eq("done_one_cycle", done, 1'b0);
      check_eq("err_held", err, e.err);
    end
  endtask

  initial begin
    #12;
    check_eq("rst_s", s, 1'b0);
    check_eq("rst_r", r, 1'b0);
    check_eq("rst_en", en, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_ready", req_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;

    do_req(1'b1, 1'b0, LAT_OK, 1'b1, 1'b0);          // set from q=0
    do_req(1'b1, 1'b0, LAT_RED, PULSE_RED, 1'b0);    // set while already set
    do_req(1'b0, 1'b0, LAT_OK, 1'b1, 1'b0);          // clear from q=1

    @(negedge clk);
    fb_mode = 1;                                      // q stuck at 0
    do_req(1'b1, 1'b1, LAT_TO, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("err_sticky", err, 1'b1);
      check_eq("idle_done", done, 1'b0);
    end

    @(negedge clk);
    fb_mode = 2;                                      // q==qn invalid feedback
    do_req(1'b0, 1'b1, LAT_TO, 1'b1, 1'b0);

    @(negedge clk);
    fb_mode = 0;
    do_req(1'b1, 1'b0, LAT_OK, 1'b1, 1'b1);          // valid held throughout
    do_req(1'b0, 1'b0, LAT_OK, 1'b1, 1'b0);          // accepted in the done cycle

    // Reset while the pulse is being driven.
    @(negedge clk);
    req_valid = 1'b1;
    req_val   = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #2;
    check_eq("pre_reset_s", s, 1'b1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_s", s, 1'b0);
    check_eq("mid_rst_r", r, 1'b0);
    check_eq("mid_rst_en", en, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_done", done, 1'b0);
    check_eq("mid_rst_err", err, 1'b0);
    check_eq("mid_rst_ready", req_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    do_req(1'b1, 1'b0, LAT_OK, 1'b1, 1'b0);          // recovery after reset

    check_eq("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
